// File: rtl/mult_pkg.sv
// Shared types and WIDTH-derived constants for the sequential signed multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The counter must hold WIDTH-1 and still compare cleanly, so it carries one extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/addsub_ext.sv
// Combinational WIDTH+1-bit sign-extending adder/subtractor built as a ripple chain.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the inputs.
//
// Ports:
//   a, b : WIDTH-bit two's-complement operands, sign-extended internally to WIDTH+1 bits
//   sub  : 0 -> a + b, 1 -> a - b (computed as a + ~b + 1)
//   sum  : WIDTH+1-bit result; carry out of the top bit is dropped
module addsub_ext #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] carry;

    assign a_ext    = {a[WIDTH-1], a};
    // Inverting b and injecting sub as carry-in gives the two's-complement subtract.
    assign b_ext    = {b[WIDTH-1], b} ^ {(WIDTH + 1){sub}};
    assign carry[0] = sub;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
        assign sum[i] = a_ext[i] ^ b_ext[i] ^ carry[i];
        if (i < WIDTH) begin : g_carry
            assign carry[i+1] = (a_ext[i] & b_ext[i]) | (carry[i] & (a_ext[i] ^ b_ext[i]));
        end
    end

endmodule

// File: rtl/seq_signed_multiplier.sv
// Sequential add-shift two's-complement multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Latency: Done pulses 2*WIDTH cycles after the Start-accept edge; one result per 2*WIDTH+2 cycles.
// Backpressure: Start is only sampled in IDLE; requests while Busy are dropped.
//
// Ports:
//   Clk, Reset            : rising-edge clock, synchronous active-high reset
//   Start                 : request, accepted only when idle
//   Multiplicand (S)      : signed operand, captured on the accept edge
//   Multiplier (M)        : signed operand, captured on the accept edge
//   Busy                  : high whenever the FSM is not idle
//   Done                  : one-cycle pulse, Product holds the final result
//   X                     : sign-extension bit above the upper accumulator
//   Product               : {A,B}; intermediate while Busy, held after Done until the next accept
module seq_signed_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic                 Busy,
    output logic                 Done,
    output logic                 X,
    output logic [2*WIDTH-1:0]   Product
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic             x_q, x_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             last_bit;
    logic [WIDTH:0]   addsub_sum;

    // The final multiplier bit carries negative weight, so its partial product is subtracted.
    assign last_bit = (cnt_q == CNT_LAST);

    addsub_ext #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a   (a_q),
        .b   (s_q),
        .sub (last_bit),
        .sum (addsub_sum)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    s_d     = Multiplicand;
                    b_d     = Multiplier;
                    a_d     = '0;
                    x_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (b_q[0]) begin
                    {x_d, a_d} = addsub_sum;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                // Arithmetic right shift of {X,A,B}; X replicates into A's top bit.
                a_d     = {x_q, a_q[WIDTH-1:1]};
                b_d     = {a_q[0], b_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = last_bit ? DONE : ADD;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status flags are registered from the next state so they line up with state_q.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            x_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign X       = x_q;
    assign Product = {a_q, b_q};

endmodule

// File: tb/tb_seq_signed_multiplier.sv
module tb_seq_signed_multiplier;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8;
    logic [7:0]  mc8, mr8;
    logic        busy8, done8, x8;
    logic [15:0] prod8;

    logic        start4;
    logic [3:0]  mc4, mr4;
    logic        busy4, done4, x4;
    logic [7:0]  prod4;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] sb8[$];
    logic [7:0]  sb4[$];

    always #5 clk = ~clk;

    seq_signed_multiplier #(.WIDTH(8)) dut8 (
        .Clk(clk), .Reset(rst), .Start(start8), .Multiplicand(mc8), .Multiplier(mr8),
        .Busy(busy8), .Done(done8), .X(x8), .Product(prod8)
    );

    seq_signed_multiplier #(.WIDTH(4)) dut4 (
        .Clk(clk), .Reset(rst), .Start(start4), .Multiplicand(mc4), .Multiplier(mr4),
        .Busy(busy4), .Done(done4), .X(x4), .Product(prod4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation; optionally hammers Start and the operands while busy.
    task automatic op8(input logic signed [7:0] s, input logic signed [7:0] m, input bit disturb);
        logic signed [15:0] p;
        logic [15:0] exp;
        int lat, busy_n;
        p = s * m;
        sb8.push_back(p);
        start8 = 1'b1; mc8 = s; mr8 = m;
        tick();
        start8 = 1'b0;
        check("w8_busy_rise", 32'(busy8), 1);
        lat = -1; busy_n = 1;
        for (int k = 1; k <= 40; k++) begin
            if (disturb) begin
                start8 = 1'($urandom_range(0, 1));
                mc8 = 8'($urandom);
                mr8 = 8'($urandom);
            end
            tick();
            if (busy8) busy_n++;
            if (done8) begin lat = k; break; end
        end
        start8 = 1'b0;
        check("w8_done_latency", 32'(lat), 16);
        if (sb8.size() == 0) begin
            check("w8_sb_empty", 32'(sb8.size()), 1);
            exp = 'x;
        end else begin
            exp = sb8.pop_front();
        end
        check("w8_product", 32'(prod8), 32'(exp));
        tick();
        check("w8_done_single", 32'(done8), 0);
        check("w8_busy_fall", 32'(busy8), 0);
        check("w8_busy_cycles", 32'(busy_n), 17);
        check("w8_product_held", 32'(prod8), 32'(exp));
    endtask

    task automatic op4(input logic signed [3:0] s, input logic signed [3:0] m);
        logic signed [7:0] p;
        logic [7:0] exp;
        int lat;
        p = s * m;
        sb4.push_back(p);
        start4 = 1'b1; mc4 = s; mr4 = m;
        tick();
        start4 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done4) begin lat = k; break; end
        end
        check("w4_done_latency", 32'(lat), 8);
        if (sb4.size() == 0) begin
            check("w4_sb_empty", 32'(sb4.size()), 1);
            exp = 'x;
        end else begin
            exp = sb4.pop_front();
        end
        check("w4_product", 32'(prod4), 32'(exp));
        tick();
        check("w4_busy_fall", 32'(busy4), 0);
    endtask

    initial begin
        int done_at[$];
        int dn;
        rst = 1'b1;
        start8 = 1'b0; mc8 = '0; mr8 = '0;
        start4 = 1'b0; mc4 = '0; mr4 = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_product", 32'(prod8), 0);
        check("rst_x", 32'(x8), 0);
        check("rst_w4_product", 32'(prod4), 0);
        rst = 1'b0;
        tick();

        // Directed WIDTH=8 cases, including the most-negative corner.
        op8(8'sd7, -8'sd3, 1'b0);
        check("w8_hex_7x-3", 32'(prod8), 32'h0000FFEB);
        check("w8_x_negative", 32'(x8), 1);
        op8(-8'sd128, -8'sd128, 1'b0);
        check("w8_hex_min_sq", 32'(prod8), 32'h00004000);
        op8(-8'sd1, -8'sd1, 1'b0);
        check("w8_hex_m1_sq", 32'(prod8), 32'h00000001);
        op8(8'sh55, 8'sd0, 1'b0);
        check("w8_hex_zero", 32'(prod8), 32'h00000000);

        // Start toggled and operands scrambled while busy must not matter.
        op8(8'sd7, -8'sd3, 1'b1);
        op8(-8'sd100, 8'sd77, 1'b1);
        op8(8'sd127, -8'sd128, 1'b1);

        // Start held high: results every 2*WIDTH+2 cycles with re-captured operands.
        start8 = 1'b1; mc8 = 8'sd13; mr8 = -8'sd11;
        for (int i = 0; i < 3; i++) sb8.push_back(16'hFF71);
        for (int k = 0; k < 60; k++) begin
            tick();
            if (k == 39) start8 = 1'b0;
            if (done8) begin
                done_at.push_back(k);
                dn = 32'(prod8);
                check("held_product", 32'(dn), 32'(sb8.pop_front()));
            end
        end
        check("held_done_count", 32'(done_at.size()), 3);
        if (done_at.size() >= 2) check("held_done_spacing", 32'(done_at[1] - done_at[0]), 18);
        if (done_at.size() >= 1) check("held_first_done", 32'(done_at[0]), 16);
        done_at.delete();
        repeat (3) tick();

        // Reset during cycle 5 of an operation abandons it silently.
        start8 = 1'b1; mc8 = 8'sd45; mr8 = 8'sd99;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", 32'(busy8), 0);
        check("midrst_product", 32'(prod8), 0);
        check("midrst_done", 32'(done8), 0);
        rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done8) dn++;
        end
        check("midrst_no_done", 32'(dn), 0);
        op8(8'sd45, 8'sd99, 1'b0);

        // WIDTH=4: directed corner, then every operand pair.
        op4(-4'sd8, 4'sd7);
        check("w4_hex_-8x7", 32'(prod4), 32'h000000C8);
        for (int s = -8; s < 8; s++) begin
            for (int m = -8; m < 8; m++) begin
                op4(4'(s), 4'(m));
            end
        end
        check("sb8_drained", 32'(sb8.size()), 0);
        check("sb4_drained", 32'(sb4.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
